// File: rtl/ppg_beat_detector_pkg.sv
// Shared types and defaults for the PPG beat detector.
// Imported by the capture stage and the detector top.
package ppg_beat_detector_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_RISE = 2'd2
  } bd_state_e;

  localparam int DEF_HYST    = 4;
  localparam int DEF_MIN_INT = 15;
  localparam int DEF_MAX_INT = 100;

endpackage

// File: rtl/ppg_pair_capture.sv
// Pairs RED/IR samples on LED falling edges and
// runs a 4-tap moving average on the IR stream.
module ppg_pair_capture
  import ppg_beat_detector_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              i_run,
  input  logic              i_led_red,
  input  logic              i_led_ir,
  input  logic [DATA_W-1:0] i_red,
  input  logic [DATA_W-1:0] i_ir,
  output logic              o_pair_stb,
  output logic              o_fvalid,
  output logic [DATA_W-1:0] o_ir_f,
  output logic [DATA_W-1:0] o_red
);

  logic                   r_led_red;
  logic                   r_led_ir;
  logic                   r_red_have;
  logic                   r_pair_stb;
  logic [DATA_W-1:0]      r_red_s;
  logic [DATA_W-1:0]      r_red_p;
  logic [DATA_W-1:0]      r_ir_s;
  logic [2:0][DATA_W-1:0] r_tap;
  logic [1:0]             r_fill;

  logic              w_red_stb;
  logic              w_ir_stb;
  logic              w_have;
  logic [DATA_W+1:0] w_sum;

  assign w_red_stb = r_led_red & ~i_led_red;
  assign w_ir_stb  = r_led_ir & ~i_led_ir;
  // a RED strobe in the same cycle still counts as the partner
  assign w_have    = r_red_have | w_red_stb;

  assign w_sum = (DATA_W+2)'(r_ir_s)
               + (DATA_W+2)'(r_tap[0])
               + (DATA_W+2)'(r_tap[1])
               + (DATA_W+2)'(r_tap[2]);

  assign o_pair_stb = r_pair_stb;
  assign o_fvalid   = r_pair_stb & (r_fill == 2'd3);
  assign o_ir_f     = DATA_W'(w_sum >> 2);
  assign o_red      = r_red_p;

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_led_red  <= 1'b0;
      r_led_ir   <= 1'b0;
      r_red_have <= 1'b0;
      r_pair_stb <= 1'b0;
      r_red_s    <= '0;
      r_red_p    <= '0;
      r_ir_s     <= '0;
      r_tap      <= '0;
      r_fill     <= '0;
    end else begin
      r_led_red <= i_led_red;
      r_led_ir  <= i_led_ir;
      if (!i_run) begin
        r_red_have <= 1'b0;
        r_pair_stb <= 1'b0;
        r_tap      <= '0;
        r_fill     <= '0;
      end else begin
        r_pair_stb <= w_ir_stb & w_have;
        if (w_red_stb)
          r_red_s <= i_red;
        if (w_ir_stb)
          r_red_have <= 1'b0;
        else if (w_red_stb)
          r_red_have <= 1'b1;
        if (w_ir_stb & w_have) begin
          r_ir_s  <= i_ir;
          r_red_p <= w_red_stb ? i_red : r_red_s;
        end
        if (r_pair_stb) begin
          r_tap <= {r_tap[1:0], r_ir_s};
          if (r_fill != 2'd3)
            r_fill <= r_fill + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/ppg_beat_detector.sv
// Hysteresis peak tracker on filtered IR; emits one
// interval/AC/DC record per accepted heartbeat.
module ppg_beat_detector
  import ppg_beat_detector_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int HYST    = DEF_HYST,
  parameter int MIN_INT = DEF_MIN_INT,
  parameter int MAX_INT = DEF_MAX_INT,
  parameter int CNT_W   = 8
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              run,
  input  logic              LED_RED,
  input  logic              LED_IR,
  input  logic [DATA_W-1:0] RED_ADC_Value,
  input  logic [DATA_W-1:0] IR_ADC_Value,
  output logic              beat_valid,
  output logic [CNT_W-1:0]  beat_interval,
  output logic [DATA_W-1:0] ir_ac,
  output logic [DATA_W-1:0] ir_dc,
  output logic [DATA_W-1:0] red_ac,
  output logic [DATA_W-1:0] red_dc,
  output logic              pulse_lost
);

  localparam logic [DATA_W:0]  L_HYST = (DATA_W+1)'(HYST);
  localparam logic [CNT_W-1:0] L_MIN  = CNT_W'(MIN_INT);
  localparam logic [CNT_W-1:0] L_MAX  = CNT_W'(MAX_INT);

  logic              w_pair_stb;
  logic              w_fv;
  logic [DATA_W-1:0] w_ir_f;
  logic [DATA_W-1:0] w_red;

  ppg_pair_capture #(
    .DATA_W(DATA_W)
  ) u_cap (
    .CLK       (CLK),
    .rst_n     (rst_n),
    .i_run     (run),
    .i_led_red (LED_RED),
    .i_led_ir  (LED_IR),
    .i_red     (RED_ADC_Value),
    .i_ir      (IR_ADC_Value),
    .o_pair_stb(w_pair_stb),
    .o_fvalid  (w_fv),
    .o_ir_f    (w_ir_f),
    .o_red     (w_red)
  );

  bd_state_e         r_state;
  logic [DATA_W-1:0] r_run_min;
  logic [DATA_W-1:0] r_run_max;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_have_pk;
  logic [DATA_W-1:0] r_imin;
  logic [DATA_W-1:0] r_imax;
  logic [DATA_W-1:0] r_rmin;
  logic [DATA_W-1:0] r_rmax;
  logic              r_bv;
  logic              r_pl;
  logic [CNT_W-1:0]  r_int;
  logic [DATA_W-1:0] r_iac;
  logic [DATA_W-1:0] r_idc;
  logic [DATA_W-1:0] r_rac;
  logic [DATA_W-1:0] r_rdc;

  bd_state_e         w_state_nxt;
  logic [DATA_W-1:0] w_min_nxt;
  logic [DATA_W-1:0] w_max_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_pk_nxt;
  logic              w_seed;
  logic              w_emit;
  logic              w_lost;

  logic              w_go;
  logic [CNT_W-1:0]  w_cnt_inc;
  logic              w_rise;
  logic              w_peak;
  logic [DATA_W-1:0] w_imin;
  logic [DATA_W-1:0] w_imax;
  logic [DATA_W-1:0] w_rmin;
  logic [DATA_W-1:0] w_rmax;
  logic [DATA_W:0]   w_idc_s;
  logic [DATA_W:0]   w_rdc_s;

  assign w_go      = w_pair_stb & w_fv;
  assign w_cnt_inc = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign w_rise    = {1'b0, w_ir_f} >= {1'b0, r_run_min} + L_HYST;
  assign w_peak    = {1'b0, w_ir_f} + L_HYST <= {1'b0, r_run_max};

  assign w_imin  = (w_ir_f < r_imin) ? w_ir_f : r_imin;
  assign w_imax  = (w_ir_f > r_imax) ? w_ir_f : r_imax;
  assign w_rmin  = (w_red < r_rmin) ? w_red : r_rmin;
  assign w_rmax  = (w_red > r_rmax) ? w_red : r_rmax;
  assign w_idc_s = {1'b0, w_imax} + {1'b0, w_imin};
  assign w_rdc_s = {1'b0, w_rmax} + {1'b0, w_rmin};

  always_comb begin
    w_state_nxt = r_state;
    w_min_nxt   = r_run_min;
    w_max_nxt   = r_run_max;
    w_cnt_nxt   = r_cnt;
    w_pk_nxt    = r_have_pk;
    w_seed      = 1'b0;
    w_emit      = 1'b0;
    w_lost      = 1'b0;
    if (w_go) begin
      w_cnt_nxt = w_cnt_inc;
      unique case (r_state)
        ST_IDLE: begin
          w_state_nxt = ST_FALL;
          w_min_nxt   = w_ir_f;
          w_max_nxt   = w_ir_f;
          w_cnt_nxt   = '0;
          w_seed      = 1'b1;
        end
        ST_FALL: begin
          if (w_rise) begin
            w_state_nxt = ST_RISE;
            w_max_nxt   = w_ir_f;
          end else if (w_ir_f < r_run_min) begin
            w_min_nxt = w_ir_f;
          end
        end
        ST_RISE: begin
          if (w_peak) begin
            w_state_nxt = ST_FALL;
            w_min_nxt   = w_ir_f;
            if (!r_have_pk) begin
              w_pk_nxt  = 1'b1;
              w_cnt_nxt = '0;
              w_seed    = 1'b1;
            end else if (w_cnt_inc >= L_MIN) begin
              w_emit    = 1'b1;
              w_cnt_nxt = '0;
              w_seed    = 1'b1;
            end
          end else if (w_ir_f > r_run_max) begin
            w_max_nxt = w_ir_f;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
      // timeout overrides a coincident peak
      if (r_state != ST_IDLE && w_cnt_inc >= L_MAX) begin
        w_lost      = 1'b1;
        w_emit      = 1'b0;
        w_pk_nxt    = 1'b0;
        w_state_nxt = ST_FALL;
        w_min_nxt   = w_ir_f;
        w_cnt_nxt   = '0;
        w_seed      = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_run_min <= '0;
      r_run_max <= '0;
      r_cnt     <= '0;
      r_have_pk <= 1'b0;
      r_imin    <= '0;
      r_imax    <= '0;
      r_rmin    <= '0;
      r_rmax    <= '0;
      r_bv      <= 1'b0;
      r_pl      <= 1'b0;
      r_int     <= '0;
      r_iac     <= '0;
      r_idc     <= '0;
      r_rac     <= '0;
      r_rdc     <= '0;
    end else if (!run) begin
      r_state   <= ST_IDLE;
      r_run_min <= '0;
      r_run_max <= '0;
      r_cnt     <= '0;
      r_have_pk <= 1'b0;
      r_bv      <= 1'b0;
      r_pl      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_run_min <= w_min_nxt;
      r_run_max <= w_max_nxt;
      r_cnt     <= w_cnt_nxt;
      r_have_pk <= w_pk_nxt;
      r_bv      <= w_emit;
      r_pl      <= w_lost;
      if (w_emit) begin
        r_int <= w_cnt_inc;
        r_iac <= w_imax - w_imin;
        r_idc <= DATA_W'(w_idc_s >> 1);
        r_rac <= w_rmax - w_rmin;
        r_rdc <= DATA_W'(w_rdc_s >> 1);
      end
      if (w_seed) begin
        r_imin <= w_ir_f;
        r_imax <= w_ir_f;
        r_rmin <= w_red;
        r_rmax <= w_red;
      end else if (w_go) begin
        r_imin <= w_imin;
        r_imax <= w_imax;
        r_rmin <= w_rmin;
        r_rmax <= w_rmax;
      end
    end
  end

  assign beat_valid    = r_bv;
  assign pulse_lost    = r_pl;
  assign beat_interval = r_int;
  assign ir_ac         = r_iac;
  assign ir_dc         = r_idc;
  assign red_ac        = r_rac;
  assign red_dc        = r_rdc;

endmodule

// File: tb/tb_ppg_beat_detector.sv
// Bench for ppg_beat_detector: pair-level reference
// model with a per-cycle output compare.
module tb_ppg_beat_detector;

  localparam int HY   = 4;
  localparam int MINI = 15;
  localparam int MAXI = 100;

  logic       CLK = 1'b0;
  logic       rst_n = 1'b1;
  logic       run = 1'b0;
  logic       LED_RED = 1'b0;
  logic       LED_IR = 1'b0;
  logic [7:0] RED_ADC_Value = '0;
  logic [7:0] IR_ADC_Value = '0;
  logic       beat_valid;
  logic [7:0] beat_interval;
  logic [7:0] ir_ac;
  logic [7:0] ir_dc;
  logic [7:0] red_ac;
  logic [7:0] red_dc;
  logic       pulse_lost;

  ppg_beat_detector dut (
    .CLK          (CLK),
    .rst_n        (rst_n),
    .run          (run),
    .LED_RED      (LED_RED),
    .LED_IR       (LED_IR),
    .RED_ADC_Value(RED_ADC_Value),
    .IR_ADC_Value (IR_ADC_Value),
    .beat_valid   (beat_valid),
    .beat_interval(beat_interval),
    .ir_ac        (ir_ac),
    .ir_dc        (ir_dc),
    .red_ac       (red_ac),
    .red_dc       (red_dc),
    .pulse_lost   (pulse_lost)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // reference model state
  typedef struct {
    int cyc;
    bit lost;
    int iv, iac, idc, rac, rdc;
  } ev_t;

  ev_t evq[$];
  int  hist[$];
  int  wf[$];
  int  wr[$];
  bit  armed, rising, havepk, m_red_have;
  int  ext, since, m_red;
  int  h_iv, h_iac, h_idc, h_rac, h_rdc;
  int  n_bv = 0;
  int  n_pl = 0;

  function automatic int qmin(input int q[$]);
    int m = q[0];
    foreach (q[k]) if (q[k] < m) m = q[k];
    return m;
  endfunction

  function automatic int qmax(input int q[$]);
    int m = q[0];
    foreach (q[k]) if (q[k] > m) m = q[k];
    return m;
  endfunction

  function automatic void win_reset(input int f, input int r);
    wf.delete();
    wr.delete();
    wf.push_back(f);
    wr.push_back(r);
  endfunction

  function automatic void model_clear();
    hist.delete();
    armed = 0;
    rising = 0;
    havepk = 0;
    m_red_have = 0;
    since = 0;
  endfunction

  function automatic void model_pair(input int r, input int i, input int c);
    int f;
    bit peak;
    ev_t e;
    hist.push_back(i);
    if (hist.size() > 4) void'(hist.pop_front());
    if (hist.size() < 4) return;
    f = (hist[0] + hist[1] + hist[2] + hist[3]) / 4;
    if (!armed) begin
      armed = 1; rising = 0; havepk = 0; ext = f; since = 0;
      win_reset(f, r);
      return;
    end
    since++;
    wf.push_back(f);
    wr.push_back(r);
    peak = 0;
    if (rising) begin
      if (f + HY <= ext) peak = 1;
      else if (f > ext) ext = f;
    end else begin
      if (f >= ext + HY) begin rising = 1; ext = f; end
      else if (f < ext) ext = f;
    end
    if (since >= MAXI) begin
      e = '{cyc: c + 2, lost: 1, iv: 0, iac: 0, idc: 0, rac: 0, rdc: 0};
      evq.push_back(e);
      havepk = 0; rising = 0; ext = f; since = 0;
      win_reset(f, r);
      return;
    end
    if (peak) begin
      rising = 0;
      ext = f;
      if (!havepk) begin
        havepk = 1; since = 0;
        win_reset(f, r);
      end else if (since >= MINI) begin
        e.cyc = c + 2;
        e.lost = 0;
        e.iv  = since;
        e.iac = qmax(wf) - qmin(wf);
        e.idc = (qmax(wf) + qmin(wf)) / 2;
        e.rac = qmax(wr) - qmin(wr);
        e.rdc = (qmax(wr) + qmin(wr)) / 2;
        evq.push_back(e);
        since = 0;
        win_reset(f, r);
      end
    end
  endfunction

  // compare process: every cycle
  initial begin
    forever begin
      bit eb, ep;
      ev_t e;
      @(negedge CLK);
      eb = 0;
      ep = 0;
      while (evq.size() > 0 && evq[0].cyc < cyc) begin
        void'(evq.pop_front());
        chk("event_missed_slot", 0, 1);
      end
      if (evq.size() > 0 && evq[0].cyc == cyc) begin
        e = evq.pop_front();
        if (e.lost) ep = 1;
        else begin
          eb = 1;
          h_iv = e.iv; h_iac = e.iac; h_idc = e.idc;
          h_rac = e.rac; h_rdc = e.rdc;
        end
      end
      chk("beat_valid", int'(beat_valid), int'(eb));
      chk("pulse_lost", int'(pulse_lost), int'(ep));
      chk("beat_interval", int'(beat_interval), h_iv);
      chk("ir_ac", int'(ir_ac), h_iac);
      chk("ir_dc", int'(ir_dc), h_idc);
      chk("red_ac", int'(red_ac), h_rac);
      chk("red_dc", int'(red_dc), h_rdc);
      if (beat_valid) n_bv++;
      if (pulse_lost) n_pl++;
    end
  end

  // drivers: all called and returning on a negedge
  task automatic red_phase(input int v);
    RED_ADC_Value = 8'(v);
    LED_RED = 1'b1;
    repeat (9) @(negedge CLK);
    LED_RED = 1'b0;
    m_red = v;
    m_red_have = 1;
    @(negedge CLK);
  endtask

  task automatic ir_phase(input int v);
    IR_ADC_Value = 8'(v);
    LED_IR = 1'b1;
    repeat (9) @(negedge CLK);
    LED_IR = 1'b0;
    if (m_red_have) model_pair(m_red, v, cyc);
    m_red_have = 0;
    @(negedge CLK);
  endtask

  task automatic pair(input int r, input int i);
    red_phase(r);
    ir_phase(i);
  endtask

  task automatic zero_outputs(input string tag);
    chk({tag, "_bv"}, int'(beat_valid), 0);
    chk({tag, "_pl"}, int'(pulse_lost), 0);
    chk({tag, "_iv"}, int'(beat_interval), 0);
    chk({tag, "_iac"}, int'(ir_ac), 0);
    chk({tag, "_idc"}, int'(ir_dc), 0);
    chk({tag, "_rac"}, int'(red_ac), 0);
    chk({tag, "_rdc"}, int'(red_dc), 0);
  endtask

  task automatic hw_reset(input int hold);
    @(posedge CLK);
    #2;
    rst_n = 1'b0;
    model_clear();
    evq.delete();
    h_iv = 0; h_iac = 0; h_idc = 0; h_rac = 0; h_rdc = 0;
    #1;
    zero_outputs("rst_immediate");
    repeat (hold) @(posedge CLK);
    #2;
    rst_n = 1'b1;
    @(negedge CLK);
  endtask

  task automatic run_low(input int n);
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #2;
    run = 1'b0;
    model_clear();
    repeat (n) @(posedge CLK);
    #2;
    run = 1'b1;
    @(negedge CLK);
  endtask

  function automatic int tri_w(input int k, input int lo, input int hi, input int per);
    int half = per / 2;
    int p = k % per;
    int step = (hi - lo) / half;
    if (p <= half) return lo + step * p;
    return lo + step * half - step * (p - half);
  endfunction

  function automatic int clamp8(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  task automatic tri_pairs(input int n, input bit spike, input int orphan_at);
    for (int k = 0; k < n; k++) begin
      int ir = tri_w(k, 100, 200, 50);
      int rd = 80 + (ir - 100) * 60 / 100;
      if (spike && (k % 50 == 37 || k % 50 == 38)) ir = ir + 40;
      if (k == orphan_at) ir_phase(0);
      pair(rd, ir);
    end
  endtask

  initial begin
    int b0, l0, tot;
    h_iv = 0; h_iac = 0; h_idc = 0; h_rac = 0; h_rdc = 0;
    model_clear();
    #1;
    rst_n = 1'b0;
    #1;
    zero_outputs("reset_state");
    repeat (3) @(posedge CLK);
    #2;
    rst_n = 1'b1;
    run = 1'b1;
    @(negedge CLK);

    // 1: clean triangle, 50-pair period
    b0 = n_bv;
    tri_pairs(300, 0, -1);
    chk("t1_beats", n_bv - b0, 5);
    chk("t1_interval", int'(beat_interval), 50);
    chk("t1_red_ac", int'(red_ac), 60);
    chk("t1_red_dc", int'(red_dc), 110);
    chk("t1_ir_ac_range", int'(ir_ac >= 90 && ir_ac <= 100), 1);
    chk("t1_model_interval", h_iv, 50);
    chk("t1_model_red_ac", h_rac, 60);

    // 2: flat input -> periodic timeouts only
    run_low(10);
    b0 = n_bv;
    l0 = n_pl;
    for (int k = 0; k < 210; k++) pair(128, 128);
    chk("t2_beats", n_bv - b0, 0);
    chk("t2_lost", n_pl - l0, 2);

    // 3+4: spurious peak each period, one orphan IR phase
    run_low(10);
    b0 = n_bv;
    l0 = n_pl;
    tri_pairs(300, 1, 60);
    chk("t3_beats", n_bv - b0, 5);
    chk("t3_lost", n_pl - l0, 0);
    chk("t3_interval", int'(beat_interval), 50);

    // 5: reset while rising
    run_low(10);
    tri_pairs(60, 0, -1);
    hw_reset(3);
    b0 = n_bv;
    tri_pairs(150, 0, -1);
    chk("t5_beats", n_bv - b0, 2);

    // 6: run low mid-beat, then cold-start behaviour
    tri_pairs(20, 0, -1);
    run_low(25);
    b0 = n_bv;
    tri_pairs(150, 0, -1);
    chk("t6_beats", n_bv - b0, 2);
    chk("t6_interval", int'(beat_interval), 50);

    // 7: randomized segments with noise and dropped RED phases
    run_low(10);
    tot = 0;
    while (tot < 400) begin
      int per = $urandom_range(10, 60) * 2;
      int lo  = $urandom_range(20, 100);
      int amp = $urandom_range(10, 120);
      for (int k = 0; k < per; k++) begin
        int base = tri_w(k, lo, lo + amp, per);
        int nz   = int'($urandom_range(0, 6)) - 3;
        int ir   = clamp8(base + nz);
        int rd   = clamp8(60 + (base - lo) / 2 + nz);
        if ($urandom_range(0, 24) == 0) ir_phase(ir);
        else pair(rd, ir);
        tot++;
      end
    end

    repeat (5) @(negedge CLK);
    chk("end_queue_empty", evq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
